led_serial_subtractor: RTL
==========================

Name: led_serial_subtractor

Overview:
Bit-serial, sequential counterpart to the board's combinational switch adder. It computes A - B instead of A + B. A = {sw2, sw1} and B = {sw4, sw3}, both taken from debounced switches. The block processes one bit per clock, LSB first, through a single borrow flip-flop, then shows {borrow, diff} on the three LEDs. It sits at top level between the raw switch pins and the LED pins.

Parameters:
WIDTH, 2, operand width in bits; the result is WIDTH bits plus a borrow bit.
DEBOUNCE_CYCLES, 250000, consecutive stable cycles a synchronised switch needs before its debounced value changes (10 ms at 25 MHz).

Ports:
clk    input   1  system clock, the only clock
rst    input   1  asynchronous, active-high reset
sw1    input   1  raw switch, operand A bit 0
sw2    input   1  raw switch, operand A bit 1
sw3    input   1  raw switch, operand B bit 0
sw4    input   1  raw switch, operand B bit 1
LED_1  output  1  borrow out (1 when A < B)
LED_2  output  1  difference bit 1
LED_3  output  1  difference bit 0
busy   output  1  high while a subtraction is in progress

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high (rst). Every flop clears on rst asserting, with no dependence on clk.
- Reset values: LED_1 = LED_2 = LED_3 = 0; busy = 0; state = IDLE; debounced switches = 0; borrow = 0; pending = 0.
- Input conditioning, per switch:
  - 2-FF synchroniser feeds a debounce counter.
  - The counter increments while the synchronised value differs from the debounced value; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced value takes the new level and the counter clears.
  - A bounce shorter than DEBOUNCE_CYCLES never reaches the debounced output.
- Change event: any debounced bit toggling, detected as a 1-cycle pulse by comparing against the previous cycle.
- State machine (IDLE, LOAD, SHIFT, DONE):
  - IDLE: on a change event, go to LOAD.
  - LOAD: 1 cycle. Copy the debounced A and B into shift registers, clear borrow, clear the bit index, clear pending, go to SHIFT.
  - SHIFT: exactly WIDTH cycles. Each cycle:
    - d = a0 ^ b0 ^ borrow
    - borrow_next = (~a0 & b0) | (~(a0 ^ b0) & borrow)
    - shift d into the result register from the MSB end; shift A and B right.
    - After bit WIDTH-1, go to DONE.
  - DONE: 1 cycle. Load the LED register with {borrow, result}, presented as LED_1 = borrow, LED_2 = result[1], LED_3 = result[0]. Then:
    - if pending = 1, go to LOAD;
    - otherwise go to IDLE.
- LED update rule: the LEDs update only in DONE, so partial results are never visible.
- busy: high in LOAD, SHIFT and DONE; low in IDLE.
- Latency: LEDs change on the clock edge WIDTH+2 cycles after the change-event pulse (4 cycles for WIDTH = 2).
- Change event while busy: set pending. The operation in flight completes with its latched operands, then one extra pass runs on the current debounced values. Multiple events while busy collapse into that single extra pass.
- Change event in the same cycle as DONE: treated as pending, so DONE goes to LOAD.
- Arithmetic: result = (A - B) mod 2^WIDTH and borrow = (A < B). This is identical to the WIDTH+1-bit two's-complement subtraction {1'b0,A} - {1'b0,B}.
- Reset mid-operation: the in-flight result is discarded and the LEDs return to 0.
- After reset release, the switches still read as debounced 0. Switches already held high produce change events once their debounce completes, so the display self-corrects.

Decomposition:
- Shared package: state encoding constants (IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3) and the default DEBOUNCE_CYCLES.
- Sub-module switch_debounce: synchroniser plus counter, parameterised by DEBOUNCE_CYCLES, one instance per switch.
- The serial subtract datapath stays in the top-level module.

Test Plan (bench runs with DEBOUNCE_CYCLES = 4):
- Reset: assert rst asynchronously mid-cycle -> LEDs 000 and busy 0 immediately, before the next clk edge.
- A = 3, B = 1 (sw1 = sw2 = sw3 = 1, sw4 = 0), held stable -> busy asserts; 4 cycles after the event pulse, LED_1, LED_2, LED_3 = 0, 1, 0.
- A = 1, B = 2 -> LEDs 1, 1, 1 (diff 3, borrow 1). A = 2, B = 2 -> LEDs 0, 0, 0.
- 2-cycle glitch on sw3 with all other switches static -> no change event; busy stays 0; LEDs unchanged.
- Start A = 3, B = 0, then change B to 3 while in SHIFT:
  - first pass shows LEDs 0, 1, 1;
  - DONE goes directly to LOAD;
  - final display is LEDs 0, 0, 0.
- Exhaustive sweep over all 16 (A, B) pairs, checking each against the reference model {1'b0,A} - {1'b0,B}. Then pulse rst during SHIFT -> LEDs clear, FSM returns to IDLE, and the next event computes correctly.

Source files
------------

// File: rtl/led_serial_subtractor_pkg.sv
// led_serial_subtractor_pkg: shared FSM encoding and debounce default for the serial subtractor.
package led_serial_subtractor_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;
  localparam int DEBOUNCE_CYCLES_DEF = 250000;
endpackage

// File: rtl/switch_debounce.sv
// switch_debounce: 2-FF synchroniser followed by a stability counter for one raw switch.
module switch_debounce
  import led_serial_subtractor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      db <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_serial_subtractor.sv
// led_serial_subtractor: debounced switches A={sw2,sw1}, B={sw4,sw3}; bit-serial A-B shown on LEDs.
module led_serial_subtractor
  import led_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw1,
  input  logic sw2,
  input  logic sw3,
  input  logic sw4,
  output logic LED_1,
  output logic LED_2,
  output logic LED_3,
  output logic busy
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state, state_n;
  logic [3:0] db, db_prev;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic [WIDTH:0] led;
  logic [IW-1:0] idx;
  logic borrow, pending, change, d, borrow_n;
  for (genvar i = 0; i < 4; i++) begin : g_db
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .rst(rst),
      .raw(i == 0 ? sw1 : i == 1 ? sw2 : i == 2 ? sw3 : sw4),
      .db (db[i])
    );
  end
  assign change = db != db_prev;
  assign d = a_sr[0] ^ b_sr[0] ^ borrow;
  assign borrow_n = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
  assign busy = state != IDLE;
  assign LED_1 = led[WIDTH];
  assign LED_2 = led[1];
  assign LED_3 = led[0];
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (change ? LOAD : IDLE) :
              state == LOAD  ? SHIFT :
              state == SHIFT ? (idx == IW'(WIDTH - 1) ? DONE : SHIFT) :
                               (pending || change ? LOAD : IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      db_prev <= '0;
      a_sr <= '0;
      b_sr <= '0;
      res <= '0;
      led <= '0;
      idx <= '0;
      borrow <= 1'b0;
      pending <= 1'b0;
    end else begin
      state <= state_n;
      db_prev <= db;
      // an event arriving in LOAD itself still earns a follow-up pass
      pending <= state == LOAD ? change : pending | (change & (state != IDLE));
      if (state == LOAD) begin
        a_sr <= WIDTH'(db[1:0]);
        b_sr <= WIDTH'(db[3:2]);
        borrow <= 1'b0;
        idx <= '0;
      end
      if (state == SHIFT) begin
        res <= {d, res[WIDTH-1:1]};
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        borrow <= borrow_n;
        idx <= idx + 1'b1;
      end
      if (state == DONE) led <= {borrow, res};
    end
  end
endmodule
